mc_control_unit: RTL and testbench

- Multicycle control FSM that sequences the single-datapath CPU (PC, Memory, IR, register bank, A/B, ALU, ALUOut, MDR, EPC, HI/LO).
- Decodes OPCODE/FUNCT from IR and drives every write enable, mux select and ALU op, one state per cycle.
- Raises overflow and undefined-opcode exceptions through EPC and a fixed vector.

---
 rtl/mc_ctrl_pkg.sv | 109 ++++++++++
 rtl/mc_ctrl_decode.sv | 125 ++++++++++++
 rtl/mc_control_unit.sv | 156 +++++++++++++++
 tb/tb_mc_control_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle CPU control unit:
//   - state_t      : FSM state encoding (also exported on state_o for debug)
//   - OP_* / FN_*  : OPCODE and FUNCT values understood by the decoder
//   - ALU_*        : ALU_Control encodings
//   - SRCB_*, PCSRC_*, REGDST_*, DATA_* : datapath mux-select encodings
//   - ctrl_t       : packed control vector produced by mc_ctrl_decode
//   - is_add_sub() : true for the R-type functs that can overflow
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_IR_LOAD    = 5'd3,
        S_DECODE     = 5'd4,
        S_R_EXEC     = 5'd5,
        S_R_WB       = 5'd6,
        S_I_EXEC     = 5'd7,
        S_I_WB       = 5'd8,
        S_MEM_ADDR   = 5'd9,
        S_LW_READ    = 5'd10,
        S_LW_WAIT    = 5'd11,
        S_LW_MDR     = 5'd12,
        S_LW_WB      = 5'd13,
        S_SW_WRITE   = 5'd14,
        S_BRANCH     = 5'd15,
        S_JUMP       = 5'd16,
        S_EPC_SAVE   = 5'd17,
        S_EXC_JUMP   = 5'd18,
        S_MD_START   = 5'd19,
        S_MD_WAIT    = 5'd20,
        S_MF_WB      = 5'd21
    } state_t;

    // OPCODE field
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // FUNCT field (R-type only)
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    // ALU operations
    localparam logic [2:0] ALU_LOAD = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    // ALU operand B
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Register-file write address
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;

    // Register-file write data
    localparam logic [1:0] DATA_ALUOUT = 2'b00;
    localparam logic [1:0] DATA_MDR    = 2'b01;
    localparam logic [1:0] DATA_HI     = 2'b10;
    localparam logic [1:0] DATA_LO     = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic       alu_out_write;
        logic       mdr_write;
        logic       epc_write;
        logic       hi_write;
        logic       lo_write;
        logic       md_start;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] data_src;
        logic [2:0] alu_control;
    } ctrl_t;

    function automatic logic is_add_sub(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational state -> control-vector table. Everything defaults to zero,
// so only the signals a state actually needs are listed.
// Build option: MULT_DIV_EN enables the MD_START / MD_WAIT / MF_WB rows;
// without it md_start, HIWrite and LOWrite stay 0.
// Ports:
//   state   in  current FSM state
//   opcode  in  IR[31:26] (selects beq vs bne in BRANCH)
//   funct   in  IR[5:0]   (ALU op in R_EXEC, HI vs LO in MF_WB)
//   eq      in  ALU A==B flag
//   md_done in  mult/div completion pulse
//   ctrl    out control vector
// -----------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       eq,
    input  logic       md_done,
    output ctrl_t      ctrl
);

`ifndef MULT_DIV_EN
    logic unused_md_done;
    assign unused_md_done = md_done;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b   = SRCB_4;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_source   = PCSRC_ALU;
                ctrl.pc_write    = 1'b1;
            end
            S_IR_LOAD: ctrl.ir_write = 1'b1;
            S_DECODE: begin
                // A/B latch the register operands while the ALU
                // precomputes the branch target into ALUOut.
                ctrl.ab_write      = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM_SL2;
                ctrl.alu_control   = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_out_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    default: ctrl.alu_control = ALU_LOAD;
                endcase
            end
            S_R_WB: begin
                ctrl.reg_dst   = REGDST_RD;
                ctrl.data_src  = DATA_ALUOUT;
                ctrl.reg_write = 1'b1;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.alu_control   = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
            end
            S_I_WB: begin
                ctrl.reg_dst   = REGDST_RT;
                ctrl.reg_write = 1'b1;
            end
            // Address stays on ALUOut for the whole memory access.
            S_LW_READ, S_LW_WAIT: ctrl.iord = 1'b1;
            S_LW_MDR: ctrl.mdr_write = 1'b1;
            S_LW_WB: begin
                ctrl.data_src  = DATA_MDR;
                ctrl.reg_dst   = REGDST_RT;
                ctrl.reg_write = 1'b1;
            end
            S_SW_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_source   = PCSRC_ALUOUT;
                ctrl.pc_write    = (opcode == OP_BNE) ? !eq : eq;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_EPC_SAVE: begin
                // PC already points past the faulting instruction.
                ctrl.alu_src_a   = 1'b0;
                ctrl.alu_src_b   = SRCB_4;
                ctrl.alu_control = ALU_SUB;
                ctrl.epc_write   = 1'b1;
            end
            S_EXC_JUMP: begin
                ctrl.pc_source = PCSRC_EXC;
                ctrl.pc_write  = 1'b1;
            end
`ifdef MULT_DIV_EN
            S_MD_START: ctrl.md_start = 1'b1;
            S_MD_WAIT: begin
                ctrl.hi_write = md_done;
                ctrl.lo_write = md_done;
            end
            S_MF_WB: begin
                ctrl.reg_dst   = REGDST_RD;
                ctrl.data_src  = (funct == FN_MFHI) ? DATA_HI : DATA_LO;
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multicycle control FSM for the single-datapath CPU. Holds the state
// register, the memory wait counter and the next-state/dispatch logic;
// control outputs come from mc_ctrl_decode.
// Build option: MULT_DIV_EN adds mult/div/mfhi/mflo; otherwise those functs
// raise the undefined-instruction exception.
// Parameters:
//   MEM_WAIT   extra cycles between address issue and valid memory data (0..3)
//   EXC_VECTOR exception PC, applied by the datapath when PCSource=11
// Ports:
//   clock, reset                 clock, async active-high reset
//   OPCODE, FUNCT                instruction fields from IR
//   Overflow, EQ                 ALU flags
//   md_done                      mult/div done pulse
//   PCWrite..md_start            write enables / start pulse
//   IorD, ALUSrcA, ALUSrcB, PCSource, RegDst, DataSrc, ALU_Control  selects
//   state_o                      current state (debug)
// -----------------------------------------------------------------------------
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int          MEM_WAIT   = 1,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       EQ,
    input  logic       md_done,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ABWrite,
    output logic       ALUOutControl,
    output logic       MDRWrite,
    output logic       EPCWrite,
    output logic       HIWrite,
    output logic       LOWrite,
    output logic       md_start,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] DataSrc,
    output logic [2:0] ALU_Control,
    output logic [4:0] state_o
);

    // Terminal count of the wait counter; meaningless when MEM_WAIT==0
    // because the wait states are then skipped entirely.
    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

    // The vector value itself lives in the datapath PC mux; it is a
    // parameter here so the whole CPU is configured from one place.
    logic [31:0] unused_exc_vector;
    assign unused_exc_vector = EXC_VECTOR;

    state_t     state_reg, state_next;
    logic [1:0] wait_cnt_reg, wait_cnt_next;
    ctrl_t      ctrl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_RESET;
            wait_cnt_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = 2'd0;   // cleared in every state that is not counting
        case (state_reg)
            S_RESET:   state_next = S_FETCH;
            S_FETCH:   state_next = (MEM_WAIT == 0) ? S_IR_LOAD : S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) state_next = S_IR_LOAD;
                else wait_cnt_next = wait_cnt_reg + 2'd1;
            end
            S_IR_LOAD: state_next = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE: begin
                        case (FUNCT)
                            FN_ADD, FN_SUB, FN_AND: state_next = S_R_EXEC;
`ifdef MULT_DIV_EN
                            FN_MULT, FN_DIV:        state_next = S_MD_START;
                            FN_MFHI, FN_MFLO:       state_next = S_MF_WB;
`endif
                            default:                state_next = S_EPC_SAVE;
                        endcase
                    end
                    OP_ADDI:       state_next = S_I_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_EPC_SAVE;
                endcase
            end
            // "and" cannot overflow, so only add/sub divert to the exception.
            S_R_EXEC:   state_next = (Overflow && is_add_sub(FUNCT)) ? S_EPC_SAVE : S_R_WB;
            S_I_EXEC:   state_next = Overflow ? S_EPC_SAVE : S_I_WB;
            S_MEM_ADDR: state_next = (OPCODE == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:  state_next = (MEM_WAIT == 0) ? S_LW_MDR : S_LW_WAIT;
            S_LW_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) state_next = S_LW_MDR;
                else wait_cnt_next = wait_cnt_reg + 2'd1;
            end
            S_LW_MDR:   state_next = S_LW_WB;
            S_EPC_SAVE: state_next = S_EXC_JUMP;
            S_MD_START: state_next = S_MD_WAIT;
            S_MD_WAIT:  if (md_done) state_next = S_FETCH;
            S_R_WB, S_I_WB, S_LW_WB, S_SW_WRITE, S_BRANCH, S_JUMP,
            S_EXC_JUMP, S_MF_WB:
                        state_next = S_FETCH;
            default:    state_next = S_RESET;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state   (state_reg),
        .opcode  (OPCODE),
        .funct   (FUNCT),
        .eq      (EQ),
        .md_done (md_done),
        .ctrl    (ctrl)
    );

    assign PCWrite       = ctrl.pc_write;
    assign MemWrite      = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign RegWrite      = ctrl.reg_write;
    assign ABWrite       = ctrl.ab_write;
    assign ALUOutControl = ctrl.alu_out_write;
    assign MDRWrite      = ctrl.mdr_write;
    assign EPCWrite      = ctrl.epc_write;
    assign HIWrite       = ctrl.hi_write;
    assign LOWrite       = ctrl.lo_write;
    assign md_start      = ctrl.md_start;
    assign IorD          = ctrl.iord;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign PCSource      = ctrl.pc_source;
    assign RegDst        = ctrl.reg_dst;
    assign DataSrc       = ctrl.data_src;
    assign ALU_Control   = ctrl.alu_control;
    assign state_o       = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_control_unit
// Directed bench for mc_control_unit. dut_a uses MEM_WAIT=1 for most
// instruction sequences; dut_b uses MEM_WAIT=2 for the lw wait-state check.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic       clock;
    logic       reset, reset_b;
    logic [5:0] OPCODE, FUNCT;
    logic       Overflow, EQ, md_done;

    // dut_a outputs
    logic       pc_write, mem_write, ir_write, reg_write, ab_write, aluout_write;
    logic       mdr_write, epc_write, hi_write, lo_write, md_start, iord, alu_src_a;
    logic [1:0] alu_src_b, pc_source, reg_dst, data_src;
    logic [2:0] alu_control;
    logic [4:0] state_a;

    // dut_b outputs packed: [23]PCWrite [22]MemWrite [21]IRWrite [20]RegWrite
    // [19]ABWrite [18]ALUOutControl [17]MDRWrite [16]EPCWrite [15]HIWrite
    // [14]LOWrite [13]md_start [12]IorD [11]ALUSrcA [10:9]ALUSrcB
    // [8:7]PCSource [6:5]RegDst [4:3]DataSrc [2:0]ALU_Control
    logic [23:0] b_ctl;
    logic [4:0]  state_b;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    mc_control_unit #(.MEM_WAIT(1), .EXC_VECTOR(32'h0000_00FC)) dut_a (
        .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .EQ(EQ), .md_done(md_done),
        .PCWrite(pc_write), .MemWrite(mem_write), .IRWrite(ir_write),
        .RegWrite(reg_write), .ABWrite(ab_write), .ALUOutControl(aluout_write),
        .MDRWrite(mdr_write), .EPCWrite(epc_write), .HIWrite(hi_write),
        .LOWrite(lo_write), .md_start(md_start), .IorD(iord), .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b), .PCSource(pc_source), .RegDst(reg_dst),
        .DataSrc(data_src), .ALU_Control(alu_control), .state_o(state_a)
    );

    mc_control_unit #(.MEM_WAIT(2), .EXC_VECTOR(32'h0000_00FC)) dut_b (
        .clock(clock), .reset(reset_b), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .EQ(EQ), .md_done(md_done),
        .PCWrite(b_ctl[23]), .MemWrite(b_ctl[22]), .IRWrite(b_ctl[21]),
        .RegWrite(b_ctl[20]), .ABWrite(b_ctl[19]), .ALUOutControl(b_ctl[18]),
        .MDRWrite(b_ctl[17]), .EPCWrite(b_ctl[16]), .HIWrite(b_ctl[15]),
        .LOWrite(b_ctl[14]), .md_start(b_ctl[13]), .IorD(b_ctl[12]),
        .ALUSrcA(b_ctl[11]), .ALUSrcB(b_ctl[10:9]), .PCSource(b_ctl[8:7]),
        .RegDst(b_ctl[6:5]), .DataSrc(b_ctl[4:3]), .ALU_Control(b_ctl[2:0]),
        .state_o(state_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check dut_a's state.
    task automatic cyc(input string tag, input state_t s);
        @(negedge clock);
        chk(tag, {27'd0, state_a}, {27'd0, s});
    endtask

    task automatic cyc_b(input string tag, input state_t s);
        @(negedge clock);
        chk(tag, {27'd0, state_b}, {27'd0, s});
    endtask

    // Common FETCH .. DECODE prefix (MEM_WAIT=1).
    task automatic front(input string tag);
        cyc({tag, "_fetch"}, S_FETCH);
        cyc({tag, "_fwait"}, S_FETCH_WAIT);
        cyc({tag, "_irload"}, S_IR_LOAD);
        cyc({tag, "_decode"}, S_DECODE);
    endtask

    logic [3:0] br_exp;

    initial begin
        reset = 1'b1; reset_b = 1'b1;
        OPCODE = OP_RTYPE; FUNCT = FN_ADD;
        Overflow = 1'b0; EQ = 1'b0; md_done = 1'b0;
        repeat (2) @(negedge clock);

        // ---- reset state ----
        chk("reset_state", {27'd0, state_a}, {27'd0, S_RESET});
        chk("reset_outputs",
            {pc_write, mem_write, ir_write, reg_write, ab_write, aluout_write,
             mdr_write, epc_write, hi_write, lo_write, md_start, iord, alu_src_a,
             alu_src_b, pc_source, reg_dst, data_src, alu_control}, 32'd0);
        reset = 1'b0;

        // ---- add $3,$1,$2 ----
        cyc("add_fetch", S_FETCH);
        chk("add_fetch_pcwrite", pc_write, 1);
        chk("add_fetch_srcb", alu_src_b, SRCB_4);
        chk("add_fetch_alu", alu_control, ALU_ADD);
        cyc("add_fwait", S_FETCH_WAIT);
        chk("add_fwait_pcwrite", pc_write, 0);
        cyc("add_irload", S_IR_LOAD);
        chk("add_irwrite", ir_write, 1);
        cyc("add_decode", S_DECODE);
        chk("add_decode_ab", ab_write, 1);
        chk("add_decode_srcb", alu_src_b, SRCB_IMM_SL2);
        chk("add_decode_aluout", aluout_write, 1);
        cyc("add_rexec", S_R_EXEC);
        chk("add_rexec_alu", alu_control, ALU_ADD);
        chk("add_rexec_srca", alu_src_a, 1);
        chk("add_rexec_regwrite", reg_write, 0);
        cyc("add_rwb", S_R_WB);
        chk("add_rwb_regwrite", reg_write, 1);
        chk("add_rwb_regdst", reg_dst, REGDST_RD);

        // ---- sub with overflow ----
        FUNCT = FN_SUB;
        front("sub");
        cyc("sub_rexec", S_R_EXEC);
        chk("sub_rexec_alu", alu_control, ALU_SUB);
        Overflow = 1'b1;
        cyc("sub_epc", S_EPC_SAVE);
        Overflow = 1'b0;
        chk("sub_epc_write", epc_write, 1);
        chk("sub_epc_alu", alu_control, ALU_SUB);
        chk("sub_epc_srcb", alu_src_b, SRCB_4);
        chk("sub_epc_regwrite", reg_write, 0);
        cyc("sub_excjump", S_EXC_JUMP);
        chk("sub_exc_pcsrc", pc_source, PCSRC_EXC);
        chk("sub_exc_pcwrite", pc_write, 1);
        chk("sub_exc_regwrite", reg_write, 0);

        // ---- and with Overflow high must not trap ----
        FUNCT = FN_AND;
        front("and");
        cyc("and_rexec", S_R_EXEC);
        chk("and_rexec_alu", alu_control, ALU_AND);
        Overflow = 1'b1;
        cyc("and_rwb", S_R_WB);
        Overflow = 1'b0;

        // ---- beq EQ=0, beq EQ=1, bne EQ=0, bne EQ=1 ----
        br_exp = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            OPCODE = (i < 2) ? OP_BEQ : OP_BNE;
            EQ = i[0];
            front("br");
            cyc("br_state", S_BRANCH);
            chk("br_pcwrite", pc_write, br_exp[i]);
            chk("br_pcsrc", pc_source, PCSRC_ALUOUT);
            chk("br_alu", alu_control, ALU_SUB);
        end
        EQ = 1'b0;

        // ---- sw ----
        OPCODE = OP_SW;
        front("sw");
        cyc("sw_addr", S_MEM_ADDR);
        chk("sw_addr_srcb", alu_src_b, SRCB_IMM);
        cyc("sw_write", S_SW_WRITE);
        chk("sw_memwrite", mem_write, 1);
        chk("sw_iord", iord, 1);

        // ---- j ----
        OPCODE = OP_J;
        front("j");
        cyc("j_state", S_JUMP);
        chk("j_pcsrc", pc_source, PCSRC_JUMP);
        chk("j_pcwrite", pc_write, 1);

        // ---- undefined opcode ----
        OPCODE = 6'h3F;
        front("undef");
        cyc("undef_epc", S_EPC_SAVE);
        chk("undef_epcwrite", epc_write, 1);
        cyc("undef_excjump", S_EXC_JUMP);
        chk("undef_regwrite", reg_write, 0);

        // ---- mult ----
        OPCODE = OP_RTYPE; FUNCT = FN_MULT;
        front("mult");
`ifdef MULT_DIV_EN
        cyc("mult_start", S_MD_START);
        chk("mult_mdstart", md_start, 1);
        for (int i = 0; i < 31; i++) begin
            cyc("mult_wait", S_MD_WAIT);
            chk("mult_wait_hi", hi_write, 0);
        end
        md_done = 1'b1;
        cyc("mult_wait_last", S_MD_WAIT);
        chk("mult_done_hi", hi_write, 1);
        chk("mult_done_lo", lo_write, 1);
        cyc("mult_fetch", S_FETCH);
        md_done = 1'b0;
        #1;
        chk("mult_after_hi", hi_write, 0);
`else
        cyc("mult_undef", S_EPC_SAVE);
        chk("mult_mdstart", md_start, 0);
        cyc("mult_excjump", S_EXC_JUMP);
        chk("mult_hiwrite", hi_write, 0);
`endif

        // ---- reset asserted mid LW_READ ----
        OPCODE = OP_LW; FUNCT = 6'h00;
        front("lwr");
        cyc("lwr_addr", S_MEM_ADDR);
        cyc("lwr_read", S_LW_READ);
        chk("lwr_read_iord", iord, 1);
        reset = 1'b1;
        #1;
        chk("lwr_async_state", {27'd0, state_a}, {27'd0, S_RESET});
        chk("lwr_async_iord", iord, 0);
        chk("lwr_async_memwrite", mem_write, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc("lwr_fetch", S_FETCH);
        chk("lwr_fetch_pcwrite", pc_write, 1);

        // ---- lw on the MEM_WAIT=2 instance ----
        reset_b = 1'b0;
        cyc_b("lwb_fetch", S_FETCH);
        cyc_b("lwb_fwait1", S_FETCH_WAIT);
        cyc_b("lwb_fwait2", S_FETCH_WAIT);
        cyc_b("lwb_irload", S_IR_LOAD);
        cyc_b("lwb_decode", S_DECODE);
        cyc_b("lwb_addr", S_MEM_ADDR);
        chk("lwb_addr_iord", b_ctl[12], 0);
        cyc_b("lwb_read", S_LW_READ);
        chk("lwb_read_iord", b_ctl[12], 1);
        cyc_b("lwb_wait1", S_LW_WAIT);
        chk("lwb_wait1_iord", b_ctl[12], 1);
        cyc_b("lwb_wait2", S_LW_WAIT);
        chk("lwb_wait2_iord", b_ctl[12], 1);
        chk("lwb_wait2_mdr", b_ctl[17], 0);
        cyc_b("lwb_mdr", S_LW_MDR);
        chk("lwb_mdrwrite", b_ctl[17], 1);
        chk("lwb_mdr_iord", b_ctl[12], 0);
        cyc_b("lwb_wb", S_LW_WB);
        chk("lwb_wb_mdr", b_ctl[17], 0);
        chk("lwb_wb_datasrc", b_ctl[4:3], DATA_MDR);
        chk("lwb_wb_regwrite", b_ctl[20], 1);
        chk("lwb_wb_regdst", b_ctl[6:5], REGDST_RT);
        cyc_b("lwb_fetch2", S_FETCH);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
